// File: rtl/pal_timing_ctrl_pkg.sv
// Shared register map, CTRL bit positions and commit FSM states for
// the PAL timing controller.
package pal_timing_ctrl_pkg;

    localparam logic [3:0] REG_CFG      = 4'd0;
    localparam logic [3:0] REG_RLO      = 4'd1;
    localparam logic [3:0] REG_RHI      = 4'd2;
    localparam logic [3:0] REG_H48_LO   = 4'd3;
    localparam logic [3:0] REG_H48_HI   = 4'd4;
    localparam logic [3:0] REG_V48_LO   = 4'd5;
    localparam logic [3:0] REG_V48_HI   = 4'd6;
    localparam logic [3:0] REG_H128_LO  = 4'd7;
    localparam logic [3:0] REG_H128_HI  = 4'd8;
    localparam logic [3:0] REG_V128_LO  = 4'd9;
    localparam logic [3:0] REG_V128_HI  = 4'd10;
    localparam logic [3:0] REG_HPEN_LO  = 4'd11;
    localparam logic [3:0] REG_HPEN_HI  = 4'd12;
    localparam logic [3:0] REG_VPEN_LO  = 4'd13;
    localparam logic [3:0] REG_VPEN_HI  = 4'd14;
    localparam logic [3:0] REG_CTRL     = 4'd15;

    localparam int unsigned CTRL_COMMIT_BIT = 0;
    localparam int unsigned CTRL_CLR_BIT    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

endpackage

// File: rtl/pal_timing_regpair.sv
// 9-bit staged/live register: byte-wide lo/hi host writes into staging,
// staging copied to live on load.
module pal_timing_regpair #(
    parameter logic [8:0] RESET_VAL = 9'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_lo,
    input  logic       wr_hi,
    input  logic [7:0] wr_data,
    input  logic       load,
    output logic [8:0] staged,
    output logic [8:0] live
);

    logic [8:0] staged_q, staged_d;
    logic [8:0] live_q, live_d;

    always_comb begin
        staged_d = staged_q;
        if (wr_lo) staged_d[7:0] = wr_data;
        if (wr_hi) staged_d[8]   = wr_data[0];
        // Load takes the pre-edge staging value, so a same-cycle write waits for the next commit
        live_d = load ? staged_q : live_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            staged_q <= RESET_VAL;
            live_q   <= RESET_VAL;
        end else begin
            staged_q <= staged_d;
            live_q   <= live_d;
        end
    end

    assign staged = staged_q;
    assign live   = live_q;

endmodule

// File: rtl/pal_timing_ctrl.sv
// Host register block for the PAL sync generator; staged settings are
// committed atomically at the next frame boundary.
module pal_timing_ctrl
    import pal_timing_ctrl_pkg::*;
#(
    parameter logic [8:0] HINIT48K_DEF  = 9'd104,
    parameter logic [8:0] VINIT48K_DEF  = 9'd0,
    parameter logic [8:0] HINIT128K_DEF = 9'd104,
    parameter logic [8:0] VINIT128K_DEF = 9'd0,
    parameter logic [8:0] HINITPEN_DEF  = 9'd104,
    parameter logic [8:0] VINITPEN_DEF  = 9'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    input  logic [8:0] hcnt,
    input  logic [8:0] vcnt,
    input  logic       raster_int_in_progress,
    output logic [1:0] mode,
    output logic       csync_option,
    output logic       vretraceint_disable,
    output logic       rasterint_enable,
    output logic [8:0] raster_line,
    output logic [8:0] hinit48k,
    output logic [8:0] vinit48k,
    output logic [8:0] hinit128k,
    output logic [8:0] vinit128k,
    output logic [8:0] hinitpen,
    output logic [8:0] vinitpen,
    output logic       armed,
    output logic       commit_done,
    output logic       raster_pending
);

    state_t     state_q, state_d;
    logic [3:0] cfg_q, cfg_d;
    logic [3:0] cfg_live_q, cfg_live_d;
    logic [8:0] raster_line_q, raster_line_d;
    logic       rint_en_q, rint_en_d;
    logic       commit_done_q, commit_done_d;
    logic       pending_q, pending_d;
    logic       rint_prev_q, rint_prev_d;

    logic       frame_boundary, ctrl_wr, load;
    logic [8:0] st_h48, st_v48, st_h128, st_v128, st_hpen, st_vpen;

    assign frame_boundary = (hcnt == 9'd0) && (vcnt == 9'd0);
    assign ctrl_wr        = wr_en && (addr == REG_CTRL);

    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        commit_done_d = 1'b0;
        case (state_q)
            ST_IDLE:  if (ctrl_wr && wr_data[CTRL_COMMIT_BIT]) state_d = ST_ARMED;
            ST_ARMED: if (frame_boundary) begin
                state_d       = ST_IDLE;
                load          = 1'b1;
                commit_done_d = 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_d         = cfg_q;
        raster_line_d = raster_line_q;
        rint_en_d     = rint_en_q;
        if (wr_en && addr == REG_CFG) cfg_d = wr_data[3:0];
        if (wr_en && addr == REG_RLO) raster_line_d[7:0] = wr_data;
        if (wr_en && addr == REG_RHI) begin
            raster_line_d[8] = wr_data[0];
            rint_en_d        = wr_data[1];
        end
        cfg_live_d  = load ? cfg_q : cfg_live_q;
        rint_prev_d = raster_int_in_progress;
        // Set has priority over a coincident clear so no event is lost
        pending_d = pending_q;
        if (ctrl_wr && wr_data[CTRL_CLR_BIT]) pending_d = 1'b0;
        if (raster_int_in_progress && !rint_prev_q) pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cfg_q         <= '0;
            cfg_live_q    <= '0;
            raster_line_q <= '0;
            rint_en_q     <= 1'b0;
            commit_done_q <= 1'b0;
            pending_q     <= 1'b0;
            rint_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            cfg_live_q    <= cfg_live_d;
            raster_line_q <= raster_line_d;
            rint_en_q     <= rint_en_d;
            commit_done_q <= commit_done_d;
            pending_q     <= pending_d;
            rint_prev_q   <= rint_prev_d;
        end
    end

    pal_timing_regpair #(.RESET_VAL(HINIT48K_DEF)) u_h48 (
        .clk(clk), .rst_n(rst_n), .wr_lo(wr_en && addr == REG_H48_LO),
        .wr_hi(wr_en && addr == REG_H48_HI), .wr_data(wr_data), .load(load),
        .staged(st_h48), .live(hinit48k));
    pal_timing_regpair #(.RESET_VAL(VINIT48K_DEF)) u_v48 (
        .clk(clk), .rst_n(rst_n), .wr_lo(wr_en && addr == REG_V48_LO),
        .wr_hi(wr_en && addr == REG_V48_HI), .wr_data(wr_data), .load(load),
        .staged(st_v48), .live(vinit48k));
    pal_timing_regpair #(.RESET_VAL(HINIT128K_DEF)) u_h128 (
        .clk(clk), .rst_n(rst_n), .wr_lo(wr_en && addr == REG_H128_LO),
        .wr_hi(wr_en && addr == REG_H128_HI), .wr_data(wr_data), .load(load),
        .staged(st_h128), .live(hinit128k));
    pal_timing_regpair #(.RESET_VAL(VINIT128K_DEF)) u_v128 (
        .clk(clk), .rst_n(rst_n), .wr_lo(wr_en && addr == REG_V128_LO),
        .wr_hi(wr_en && addr == REG_V128_HI), .wr_data(wr_data), .load(load),
        .staged(st_v128), .live(vinit128k));
    pal_timing_regpair #(.RESET_VAL(HINITPEN_DEF)) u_hpen (
        .clk(clk), .rst_n(rst_n), .wr_lo(wr_en && addr == REG_HPEN_LO),
        .wr_hi(wr_en && addr == REG_HPEN_HI), .wr_data(wr_data), .load(load),
        .staged(st_hpen), .live(hinitpen));
    pal_timing_regpair #(.RESET_VAL(VINITPEN_DEF)) u_vpen (
        .clk(clk), .rst_n(rst_n), .wr_lo(wr_en && addr == REG_VPEN_LO),
        .wr_hi(wr_en && addr == REG_VPEN_HI), .wr_data(wr_data), .load(load),
        .staged(st_vpen), .live(vinitpen));

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_CFG:     rd_data = {4'b0, cfg_q};
            REG_RLO:     rd_data = raster_line_q[7:0];
            REG_RHI:     rd_data = {6'b0, rint_en_q, raster_line_q[8]};
            REG_H48_LO:  rd_data = st_h48[7:0];
            REG_H48_HI:  rd_data = {7'b0, st_h48[8]};
            REG_V48_LO:  rd_data = st_v48[7:0];
            REG_V48_HI:  rd_data = {7'b0, st_v48[8]};
            REG_H128_LO: rd_data = st_h128[7:0];
            REG_H128_HI: rd_data = {7'b0, st_h128[8]};
            REG_V128_LO: rd_data = st_v128[7:0];
            REG_V128_HI: rd_data = {7'b0, st_v128[8]};
            REG_HPEN_LO: rd_data = st_hpen[7:0];
            REG_HPEN_HI: rd_data = {7'b0, st_hpen[8]};
            REG_VPEN_LO: rd_data = st_vpen[7:0];
            REG_VPEN_HI: rd_data = {7'b0, st_vpen[8]};
            REG_CTRL:    rd_data = {6'b0, pending_q, state_q == ST_ARMED};
            default:     rd_data = '0;
        endcase
    end

    assign mode                = cfg_live_q[1:0];
    assign csync_option        = cfg_live_q[2];
    assign vretraceint_disable = cfg_live_q[3];
    assign rasterint_enable    = rint_en_q;
    assign raster_line         = raster_line_q;
    assign armed               = (state_q == ST_ARMED);
    assign commit_done         = commit_done_q;
    assign raster_pending      = pending_q;

endmodule

// File: tb/tb_pal_timing_ctrl.sv
// Directed bench for pal_timing_ctrl: commit timing, write-through
// registers, raster pending flag and reset during a pending commit.
module tb_pal_timing_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic [8:0] hcnt, vcnt;
    logic       raster_int_in_progress;
    logic [1:0] mode;
    logic       csync_option, vretraceint_disable, rasterint_enable;
    logic [8:0] raster_line;
    logic [8:0] hinit48k, vinit48k, hinit128k, vinit128k, hinitpen, vinitpen;
    logic       armed, commit_done, raster_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pal_timing_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .hcnt(hcnt), .vcnt(vcnt),
        .raster_int_in_progress(raster_int_in_progress),
        .mode(mode), .csync_option(csync_option),
        .vretraceint_disable(vretraceint_disable),
        .rasterint_enable(rasterint_enable), .raster_line(raster_line),
        .hinit48k(hinit48k), .vinit48k(vinit48k), .hinit128k(hinit128k),
        .vinit128k(vinit128k), .hinitpen(hinitpen), .vinitpen(vinitpen),
        .armed(armed), .commit_done(commit_done), .raster_pending(raster_pending));

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(tag, {1'b0, rd_data}, {1'b0, exp});
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
        hcnt = 9'd5; vcnt = 9'd100; raster_int_in_progress = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check("rst_hinit48k", hinit48k, 9'd104);
        check("rst_hinitpen", hinitpen, 9'd104);
        check("rst_vinit48k", vinit48k, 9'd0);
        check("rst_mode", {7'b0, mode}, 9'd0);
        check("rst_armed", {8'b0, armed}, 9'd0);
        check("rst_raster_line", raster_line, 9'd0);
        rd_check("rst_rd_ctrl", 4'd15, 8'h00);
        rd_check("rst_rd_h48lo", 4'd3, 8'd104);

        // Stage mode=2, hinitpen=0x150, then commit mid-frame
        wr(4'd0, 8'h02);
        wr(4'd11, 8'h50);
        wr(4'd12, 8'h01);
        wr(4'd15, 8'h01);
        check("arm_armed", {8'b0, armed}, 9'd1);
        check("arm_mode_held", {7'b0, mode}, 9'd0);
        check("arm_hpen_held", hinitpen, 9'd104);
        rd_check("arm_rd_cfg", 4'd0, 8'h02);
        rd_check("arm_rd_ctrl", 4'd15, 8'h01);
        hcnt = 9'd0; vcnt = 9'd100;
        tick();
        check("hzero_no_commit", {7'b0, mode}, 9'd0);
        check("hzero_no_pulse", {8'b0, commit_done}, 9'd0);
        hcnt = 9'd0; vcnt = 9'd0;
        tick();
        check("commit_mode", {7'b0, mode}, 9'd2);
        check("commit_hpen", hinitpen, 9'h150);
        check("commit_pulse", {8'b0, commit_done}, 9'd1);
        check("commit_disarm", {8'b0, armed}, 9'd0);
        hcnt = 9'd1;
        tick();
        check("commit_pulse_end", {8'b0, commit_done}, 9'd0);
        check("commit_mode_kept", {7'b0, mode}, 9'd2);

        // Write-through raster registers
        wr(4'd1, 8'h20);
        check("rlo_line", raster_line, 9'h020);
        wr(4'd2, 8'h03);
        check("rhi_line", raster_line, 9'h120);
        check("rhi_enable", {8'b0, rasterint_enable}, 9'd1);
        check("wt_no_commit", {8'b0, commit_done}, 9'd0);
        rd_check("rd_rhi", 4'd2, 8'h03);

        // Commit request on boundary while IDLE waits a full frame
        wr(4'd0, 8'h01);
        hcnt = 9'd0; vcnt = 9'd0;
        wr(4'd15, 8'h01);
        check("bnd_req_armed", {8'b0, armed}, 9'd1);
        check("bnd_req_no_pulse", {8'b0, commit_done}, 9'd0);
        check("bnd_req_mode", {7'b0, mode}, 9'd2);
        hcnt = 9'd1;
        tick();
        check("bnd_still_armed", {8'b0, armed}, 9'd1);
        wr(4'd15, 8'h01);
        check("rearm_armed", {8'b0, armed}, 9'd1);
        check("rearm_no_pulse", {8'b0, commit_done}, 9'd0);
        // Staging write on the boundary edge goes to the next commit
        hcnt = 9'd0; vcnt = 9'd0;
        wr(4'd0, 8'h03);
        check("bnd_commit_mode", {7'b0, mode}, 9'd1);
        check("bnd_commit_pulse", {8'b0, commit_done}, 9'd1);
        check("bnd_commit_disarm", {8'b0, armed}, 9'd0);
        rd_check("bnd_late_staged", 4'd0, 8'h03);
        hcnt = 9'd1;
        tick();
        check("bnd_single_pulse", {8'b0, commit_done}, 9'd0);
        hcnt = 9'd0;
        tick();
        check("idle_bnd_no_pulse", {8'b0, commit_done}, 9'd0);
        check("idle_bnd_mode", {7'b0, mode}, 9'd1);
        hcnt = 9'd1;

        // Raster pending
        raster_int_in_progress = 1'b1;
        tick();
        check("rp_set", {8'b0, raster_pending}, 9'd1);
        rd_check("rp_rd_ctrl", 4'd15, 8'h02);
        tick();
        check("rp_sticky", {8'b0, raster_pending}, 9'd1);
        wr(4'd15, 8'h02);
        check("rp_clear", {8'b0, raster_pending}, 9'd0);
        raster_int_in_progress = 1'b0;
        tick();
        check("rp_fall_no_set", {8'b0, raster_pending}, 9'd0);
        raster_int_in_progress = 1'b1;
        wr(4'd15, 8'h02);
        check("rp_set_wins", {8'b0, raster_pending}, 9'd1);

        // Reset while armed abandons the commit
        wr(4'd0, 8'h01);
        wr(4'd15, 8'h01);
        check("rst_arm_armed", {8'b0, armed}, 9'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstarm_mode", {7'b0, mode}, 9'd0);
        check("rstarm_armed", {8'b0, armed}, 9'd0);
        check("rstarm_pending", {8'b0, raster_pending}, 9'd0);
        check("rstarm_line", raster_line, 9'd0);
        rd_check("rstarm_rd_cfg", 4'd0, 8'h00);
        hcnt = 9'd0; vcnt = 9'd0;
        tick();
        check("rstarm_no_pulse", {8'b0, commit_done}, 9'd0);
        check("rstarm_mode_bnd", {7'b0, mode}, 9'd0);
        check("rstarm_hpen", hinitpen, 9'd104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
